// File: rtl/stream_source.sv
// Valid/ready burst generator: emits `beats` values seed, seed+step, ... with `gap` idle cycles between beats.
// Optional STREAM_SOURCE_LFSR_EN adds a lfsr_mode input selecting a Galois LFSR sequence instead of the adder.
module stream_source #(
    parameter int                    WIDTH     = 8,
    parameter int                    CNT_W     = 8,
    parameter int                    GAP_W     = 4,
    parameter logic [WIDTH-1:0]      LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  seed,
    input  logic [WIDTH-1:0]  step,
    input  logic [CNT_W-1:0]  beats,
    input  logic [GAP_W-1:0]  gap,
`ifdef STREAM_SOURCE_LFSR_EN
    input  logic              lfsr_mode,
`endif
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   data_r;
    logic [WIDTH-1:0]   data_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               done_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic [WIDTH-1:0]   step_r;
    logic [WIDTH-1:0]   step_s;
    logic [CNT_W-1:0]   beats_r;
    logic [CNT_W-1:0]   beats_s;
    logic [GAP_W-1:0]   gap_r;
    logic [GAP_W-1:0]   gap_s;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic [WIDTH-1:0]   first_s;
    logic [WIDTH-1:0]   next_data_s;
    logic               mode_r;
    logic               mode_s;
    logic               mode_in_s;

`ifdef STREAM_SOURCE_LFSR_EN
    assign mode_in_s = lfsr_mode;

    // Next sequence value: Galois LFSR shift or modular add.
    function automatic logic [WIDTH-1:0] next_value(
        input logic [WIDTH-1:0] prev,
        input logic [WIDTH-1:0] inc,
        input logic             lfsr
    );
        logic [WIDTH-1:0] res;
        if (lfsr) begin
            res = (prev >> 1) ^ (prev[0] ? LFSR_TAPS : {WIDTH{1'b0}});
        end else begin
            res = prev + inc;
        end
        return res;
    endfunction

    // A zero LFSR state never leaves zero, so substitute 1.
    function automatic logic [WIDTH-1:0] first_value(
        input logic [WIDTH-1:0] s,
        input logic             lfsr
    );
        logic [WIDTH-1:0] res;
        if (lfsr && (s == {WIDTH{1'b0}})) begin
            res = WIDTH'(1'b1);
        end else begin
            res = s;
        end
        return res;
    endfunction
`else
    logic [WIDTH-1:0] unused_taps_s;
    assign unused_taps_s = LFSR_TAPS;
    assign mode_in_s     = 1'b0;

    // Next sequence value: modular add only in this build.
    function automatic logic [WIDTH-1:0] next_value(
        input logic [WIDTH-1:0] prev,
        input logic [WIDTH-1:0] inc,
        input logic             lfsr
    );
        logic unused_lfsr;
        unused_lfsr = lfsr;
        return prev + inc;
    endfunction

    // Seed is used unchanged in this build.
    function automatic logic [WIDTH-1:0] first_value(
        input logic [WIDTH-1:0] s,
        input logic             lfsr
    );
        logic unused_lfsr;
        unused_lfsr = lfsr;
        return s;
    endfunction
`endif

    assign count_inc_s = count_r + CNT_W'(1'b1);
    assign first_s     = first_value(seed, mode_in_s);
    assign next_data_s = next_value(data_r, step_r, mode_r);

    // Next-state and next-output logic for the burst FSM.
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        count_s   = count_r;
        gap_cnt_s = gap_cnt_r;
        done_s    = 1'b0;
        step_s    = step_r;
        beats_s   = beats_r;
        gap_s     = gap_r;
        mode_s    = mode_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    count_s = {CNT_W{1'b0}};
                    if (beats != {CNT_W{1'b0}}) begin
                        step_s  = step;
                        beats_s = beats;
                        gap_s   = gap;
                        mode_s  = mode_in_s;
                        data_s  = first_s;
                        state_s = SEND;
                    end else begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    count_s = count_inc_s;
                    if (count_inc_s == beats_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (gap_r == {GAP_W{1'b0}}) begin
                        data_s  = next_data_s;
                        state_s = SEND;
                    end else begin
                        gap_cnt_s = gap_r;
                        state_s   = GAP;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                // The count loaded on entry equals the number of idle cycles still owed.
                if (gap_cnt_r == GAP_W'(1'b1)) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    data_s    = next_data_s;
                    state_s   = SEND;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1'b1);
                    state_s   = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched burst parameters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            step_r    <= {WIDTH{1'b0}};
            beats_r   <= {CNT_W{1'b0}};
            gap_r     <= {GAP_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            mode_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            data_r    <= data_s;
            valid_r   <= (state_s == SEND);
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
            count_r   <= count_s;
            step_r    <= step_s;
            beats_r   <= beats_s;
            gap_r     <= gap_s;
            gap_cnt_r <= gap_cnt_s;
            mode_r    <= mode_s;
        end
    end

    assign out_data   = data_r;
    assign out_valid  = valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sent_count = count_r;

endmodule

// File: tb/tb_stream_source.sv
// Randomised bench for stream_source: expected beats come from closed-form sequence rules, with
// backpressure, gap length, done timing, back-to-back start, async reset and ignored-start checks.
module tb_stream_source;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] step = 8'h00;
    logic [7:0] beats = 8'h00;
    logic [3:0] gap = 4'h0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [7:0] sent_count;
`ifdef STREAM_SOURCE_LFSR_EN
    logic       lfsr_mode = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    stream_source #(.WIDTH(8), .CNT_W(8), .GAP_W(4), .LFSR_TAPS(8'hB8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed       (seed),
        .step       (step),
        .beats      (beats),
        .gap        (gap),
`ifdef STREAM_SOURCE_LFSR_EN
        .lfsr_mode  (lfsr_mode),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value of beat i of a burst, straight from the sequence definition.
    function automatic logic [7:0] beat_value(input logic [7:0] s, input logic [7:0] st,
                                              input int i, input bit lfsr);
        logic [7:0] v;
        if (lfsr) begin
            v = (s == 8'h00) ? 8'h01 : s;
            for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
            return v;
        end
        return 8'(int'(s) + i * int'(st));
    endfunction

    // Issue start at the current negedge, follow the burst, return at the negedge showing done.
    task automatic run_burst(input logic [7:0] s, input logic [7:0] st, input logic [7:0] b,
                             input logic [3:0] g, input bit lfsr, input int ready_pct,
                             output logic [7:0] last);
        int  idx;
        int  inval;
        int  cyc;
        bit  after_hs;
        seed = s; step = st; beats = b; gap = g; start = 1'b1;
`ifdef STREAM_SOURCE_LFSR_EN
        lfsr_mode = lfsr;
`endif
        @(negedge clk);
        start = 1'b0;
        seed = 8'($urandom); step = 8'($urandom); beats = 8'($urandom); gap = 4'($urandom);
`ifdef STREAM_SOURCE_LFSR_EN
        lfsr_mode = 1'($urandom);
`endif
        if (b == 8'd0) begin
            check_val("zero_done", done, 1);
            check_val("zero_valid", out_valid, 0);
            check_val("zero_busy", busy, 0);
            check_val("zero_count", sent_count, 0);
            start = 1'b0;
            last = out_data;
            return;
        end
        idx = 0; inval = 0; cyc = 0; after_hs = 1'b0;
        while (idx < int'(b) && cyc < 2000) begin
            cyc++;
            check_val("count", sent_count, idx);
            check_val("busy", busy, 1);
            check_val("no_done", done, 0);
            if (out_valid) begin
                if (after_hs) check_val("gap_len", inval, g);
                after_hs = 1'b0;
                check_val("data", out_data, beat_value(s, st, idx, lfsr));
                out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    idx++;
                    after_hs = 1'b1;
                    inval = 0;
                end
            end else begin
                inval++;
                out_ready = 1'($urandom);
            end
            start = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (idx < int'(b)) begin
            check_val("timeout", idx, b);
        end else begin
            check_val("done", done, 1);
            check_val("end_valid", out_valid, 0);
            check_val("end_busy", busy, 0);
            check_val("end_count", sent_count, b);
            check_val("end_data", out_data, beat_value(s, st, int'(b) - 1, lfsr));
        end
        last = out_data;
    endtask

    task automatic idle_check(input logic [7:0] last);
        @(negedge clk);
        check_val("idle_done", done, 0);
        check_val("idle_valid", out_valid, 0);
        check_val("idle_hold", out_data, last);
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] s;
        logic [7:0] st;
        #2 reset = 1'b0;
        #10;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_count", sent_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_burst(8'h44, 8'h10, 8'd3, 4'd0, 1'b0, 100, last);
        idle_check(last);
        run_burst(8'h44, 8'h10, 8'd3, 4'd0, 1'b0, 40, last);
        idle_check(last);
        run_burst(8'h10, 8'h01, 8'd3, 4'd2, 1'b0, 100, last);
        idle_check(last);
        run_burst(8'hF0, 8'h20, 8'd2, 4'd0, 1'b0, 100, last);
        idle_check(last);
        run_burst(8'h5A, 8'h01, 8'd0, 4'd0, 1'b0, 100, last);
        idle_check(last);
        // Start accepted in the same cycle done is high.
        run_burst(8'h01, 8'h02, 8'd2, 4'd1, 1'b0, 100, last);
        run_burst(8'hC0, 8'hFF, 8'd4, 4'd0, 1'b0, 70, last);
        idle_check(last);

        // Asynchronous reset after the second handshake of a 5-beat burst.
        seed = 8'h20; step = 8'h03; beats = 8'd5; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_count", sent_count, 2);
        check_val("pre_rst_data", out_data, 8'h26);
        reset = 1'b0;
        #1;
        check_val("async_valid", out_valid, 0);
        check_val("async_busy", busy, 0);
        check_val("async_count", sent_count, 0);
        check_val("async_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("post_rst_valid", out_valid, 0);
        run_burst(8'h77, 8'h05, 8'd4, 4'd1, 1'b0, 80, last);
        idle_check(last);

        for (int n = 0; n < 40; n++) begin
            s  = 8'($urandom);
            st = 8'($urandom);
            run_burst(s, st, 8'($urandom_range(12)), 4'($urandom_range(3)), 1'b0,
                      int'($urandom_range(30, 100)), last);
            if ($urandom_range(1) == 0) idle_check(last);
        end

`ifdef STREAM_SOURCE_LFSR_EN
        run_burst(8'h01, 8'h33, 8'd3, 4'd0, 1'b1, 100, last);
        idle_check(last);
        run_burst(8'h00, 8'h33, 8'd3, 4'd1, 1'b1, 60, last);
        idle_check(last);
        run_burst(8'h9D, 8'h33, 8'd6, 4'd0, 1'b0, 100, last);
        idle_check(last);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
